// File: rtl/record_play_ctrl_if.sv
// record_play_ctrl_if: panel-side request and status bundle for the record/playback controller
interface record_play_ctrl_if;
  logic       fake_switch;
  logic       rec_req;
  logic       play_req;
  logic       stop_req;
  logic       loop_en;
  logic       play_out;
  logic       busy_rec;
  logic       busy_play;
  logic [4:0] entry_cnt;
  logic [4:0] play_idx;
  logic       done;
  logic       overflow;
  modport master(output fake_switch, rec_req, play_req, stop_req, loop_en,
                 input play_out, busy_rec, busy_play, entry_cnt, play_idx, done, overflow);
  modport slave(input fake_switch, rec_req, play_req, stop_req, loop_en,
                output play_out, busy_rec, busy_play, entry_cnt, play_idx, done, overflow);
endinterface

// File: rtl/record_play_ctrl.sv
// record_play_ctrl: records switch levels with tick durations into a buffer and replays them once or looped
module record_play_ctrl #(
  parameter int DEPTH    = 20,
  parameter int DUR_W    = 8,
  parameter int DUR_MAX  = 127,
  parameter int TICK_DIV = 50
) (
  input logic               Div_CLK,
  input logic               RST_n,
  record_play_ctrl_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t;
  state_t           r_state;
  logic [PW-1:0]    r_presc;
  logic [4:0]       r_wr_idx;
  logic [4:0]       r_entry_cnt;
  logic [4:0]       r_play_idx;
  logic [DUR_W-1:0] r_remain;
  logic             r_play_out;
  logic             r_done;
  logic             r_overflow;
  logic             r_level [DEPTH];
  logic [DUR_W-1:0] r_dur   [DEPTH];
  logic             w_tick;
  logic             w_edge;
  logic             w_room;
  logic             w_last;
  logic             w_start_rec;
  logic             w_rec_on;
  logic             w_wr_en;
  logic [4:0]       w_wr_idx;
  logic [DUR_W-1:0] w_wr_dur;
  logic [4:0]       w_nxt_idx;
  logic [DUR_W-1:0] w_nxt_dur;
  always_comb begin
    w_tick      = r_presc == PW'(TICK_DIV - 1);
    w_edge      = bus.fake_switch != r_level[r_wr_idx];
    w_room      = r_wr_idx < 5'(DEPTH - 1);
    w_last      = r_play_idx >= r_entry_cnt - 5'd1;
    w_start_rec = r_state == IDLE && !bus.stop_req && bus.rec_req;
    w_rec_on    = r_state == RECORD && !bus.stop_req;
    // an edge wins over a coincident tick: the closed entry keeps its count
    w_wr_en     = w_start_rec || (w_rec_on && (w_edge ? w_room : w_tick));
    w_wr_idx    = w_start_rec ? 5'd0 : w_edge ? r_wr_idx + 5'd1 : r_wr_idx;
    w_wr_dur    = (w_start_rec || w_edge) ? '0 :
                  r_dur[r_wr_idx] >= DUR_W'(DUR_MAX) ? DUR_W'(DUR_MAX) : r_dur[r_wr_idx] + DUR_W'(1);
    w_nxt_idx   = (r_state != PLAY || w_last) ? 5'd0 : r_play_idx + 5'd1;
    w_nxt_dur   = r_dur[w_nxt_idx] == '0 ? DUR_W'(1) : r_dur[w_nxt_idx];
  end
  // buffer is left unreset; entry_cnt==0 makes stale contents unreachable
  always_ff @(posedge Div_CLK)
    if (w_wr_en) begin
      r_level[w_wr_idx] <= bus.fake_switch;
      r_dur[w_wr_idx]   <= w_wr_dur;
    end
  always_ff @(posedge Div_CLK or negedge RST_n)
    if (!RST_n) begin
      r_state     <= IDLE;
      r_presc     <= '0;
      r_wr_idx    <= '0;
      r_entry_cnt <= '0;
      r_play_idx  <= '0;
      r_remain    <= '0;
      r_play_out  <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_presc <= (r_state == IDLE || w_tick) ? '0 : r_presc + PW'(1);
      case (r_state)
        IDLE:
          if (w_start_rec) begin
            r_state     <= RECORD;
            r_wr_idx    <= '0;
            r_entry_cnt <= '0;
            r_overflow  <= 1'b0;
          end else if (!bus.stop_req && bus.play_req && r_entry_cnt != '0) begin
            r_state    <= PLAY;
            r_play_idx <= '0;
            r_remain   <= w_nxt_dur;
            r_play_out <= r_level[0];
          end
        RECORD:
          if (bus.stop_req) begin
            r_entry_cnt <= r_wr_idx + 5'd1;
            r_state     <= IDLE;
          end else if (w_edge && !w_room) begin
            r_overflow  <= 1'b1;
            r_entry_cnt <= 5'(DEPTH);
            r_state     <= IDLE;
          end else if (w_edge) begin
            r_wr_idx <= r_wr_idx + 5'd1;
          end
        PLAY:
          if (bus.stop_req) begin
            r_state    <= IDLE;
            r_play_out <= 1'b0;
          end else if (w_tick && r_remain > DUR_W'(1)) begin
            r_remain <= r_remain - DUR_W'(1);
          end else if (w_tick && (!w_last || bus.loop_en)) begin
            r_play_idx <= w_nxt_idx;
            r_remain   <= w_nxt_dur;
            r_play_out <= r_level[w_nxt_idx];
          end else if (w_tick) begin
            r_done     <= 1'b1;
            r_state    <= IDLE;
            r_play_out <= 1'b0;
          end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.play_out  = r_play_out;
  assign bus.busy_rec  = r_state == RECORD;
  assign bus.busy_play = r_state == PLAY;
  assign bus.entry_cnt = r_entry_cnt;
  assign bus.play_idx  = r_play_idx;
  assign bus.done      = r_done;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_record_play_ctrl.sv
// tb_record_play_ctrl: scoreboard bench for record, playback, saturation, overflow and async reset
module tb_record_play_ctrl;
  localparam int T = 4;
  typedef struct packed {logic [4:0] idx; logic lvl;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];
  record_play_ctrl_if bus();
  record_play_ctrl #(.TICK_DIV(T)) dut (.Div_CLK(clk), .RST_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic req(input bit r, input bit p, input bit s);
    bus.rec_req = r;
    bus.play_req = p;
    bus.stop_req = s;
    cyc(1);
    bus.rec_req = 1'b0;
    bus.play_req = 1'b0;
    bus.stop_req = 1'b0;
  endtask
  task automatic seg(input bit lvl, input int n);
    bus.fake_switch = lvl;
    cyc(n);
  endtask
  task automatic push(input int idx, input bit lvl, input int dur);
    exp_t e;
    e.idx = 5'(idx);
    e.lvl = lvl;
    repeat ((dur < 1 ? 1 : dur) * T) sb.push_back(e);
  endtask
  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_out"}, bus.play_out, e.lvl);
      chk({tag, "_idx"}, bus.play_idx, e.idx);
      chk({tag, "_busy"}, bus.busy_play, 1);
      chk({tag, "_done"}, bus.done, 0);
      cyc(1);
    end
  endtask
  task automatic end_play(input string tag);
    chk({tag, "_done_pulse"}, bus.done, 1);
    chk({tag, "_busy_fall"}, bus.busy_play, 0);
    chk({tag, "_out_idle"}, bus.play_out, 0);
    cyc(1);
    chk({tag, "_done_once"}, bus.done, 0);
  endtask
  initial begin
    bus.fake_switch = 1'b0;
    bus.rec_req = 1'b0;
    bus.play_req = 1'b0;
    bus.stop_req = 1'b0;
    bus.loop_en = 1'b0;
    cyc(3);
    chk("rst_busy_rec", bus.busy_rec, 0);
    chk("rst_busy_play", bus.busy_play, 0);
    chk("rst_play_out", bus.play_out, 0);
    chk("rst_entry_cnt", bus.entry_cnt, 0);
    chk("rst_play_idx", bus.play_idx, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_overflow", bus.overflow, 0);
    rst_n = 1'b1;
    cyc(1);
    req(0, 1, 0);
    chk("empty_play_ignored", bus.busy_play, 0);
    // two entries: 12 cycles low (3 ticks), 8 cycles high (2 ticks)
    req(1, 0, 0);
    chk("rec_busy", bus.busy_rec, 1);
    chk("rec_cnt0", bus.entry_cnt, 0);
    seg(0, 12);
    seg(1, 8);
    req(0, 0, 1);
    chk("rec_stop_busy", bus.busy_rec, 0);
    chk("rec_cnt", bus.entry_cnt, 2);
    push(0, 0, 3);
    push(1, 1, 2);
    req(0, 1, 0);
    drain("play1");
    end_play("play1");
    bus.loop_en = 1'b1;
    repeat (2) begin
      push(0, 0, 3);
      push(1, 1, 2);
    end
    req(0, 1, 0);
    drain("loop");
    req(0, 0, 1);
    chk("loop_stop_busy", bus.busy_play, 0);
    chk("loop_stop_out", bus.play_out, 0);
    chk("loop_stop_done", bus.done, 0);
    bus.loop_en = 1'b0;
    // 200 ticks high saturates at 127; edge lands on a tick cycle at the end of entry 1
    bus.fake_switch = 1'b1;
    req(1, 0, 0);
    seg(1, 800);
    seg(0, 11);
    seg(1, 1);
    req(0, 0, 1);
    chk("sat_cnt", bus.entry_cnt, 3);
    push(0, 1, 127);
    push(1, 0, 2);
    push(2, 1, 0);
    req(0, 1, 0);
    drain("sat");
    end_play("sat");
    req(0, 1, 0);
    cyc(10);
    chk("pre_rst_out", bus.play_out, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", bus.play_out, 0);
    chk("arst_busy_play", bus.busy_play, 0);
    chk("arst_cnt", bus.entry_cnt, 0);
    chk("arst_idx", bus.play_idx, 0);
    chk("arst_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    req(0, 1, 0);
    chk("arst_play_ignored", bus.busy_play, 0);
    bus.fake_switch = 1'b0;
    req(1, 0, 0);
    for (int i = 1; i < 20; i++) seg(1'(i % 2), 1);
    chk("ovf_pre_busy", bus.busy_rec, 1);
    chk("ovf_pre_flag", bus.overflow, 0);
    seg(0, 1);
    chk("ovf_busy", bus.busy_rec, 0);
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_cnt", bus.entry_cnt, 20);
    req(1, 0, 1);
    chk("stoprec_busy", bus.busy_rec, 0);
    chk("stoprec_flag", bus.overflow, 1);
    chk("stoprec_cnt", bus.entry_cnt, 20);
    req(1, 0, 0);
    chk("rec2_busy", bus.busy_rec, 1);
    chk("rec2_flag_clr", bus.overflow, 0);
    chk("rec2_cnt", bus.entry_cnt, 0);
    req(0, 0, 1);
    chk("rec2_stop_cnt", bus.entry_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/record_play_ctrl.md
Name: record_play_ctrl

Overview:
Controller for the switch-recording datapath of the three-colour light. It sequences a record phase, capturing switch level changes and per-level hold durations in ticks into a DEPTH-entry buffer. It then sequences a playback phase that replays the stored levels on play_out for the stored durations, once or looped. It arbitrates record, play and stop requests from the panel logic and owns the tick prescaler.

Parameters:
DEPTH, 20, number of level/duration entries; index width 5 bits
DUR_W, 8, width of each duration entry
DUR_MAX, 127, duration saturation value in ticks
TICK_DIV, 50, Div_CLK cycles per tick; must be >= 2

Ports:
Div_CLK  in  1  system clock; all state changes on rising edge
RST_n  in  1  asynchronous active-low reset
fake_switch  in  1  switch level to record, already synchronised
rec_req  in  1  pulse: start recording
play_req  in  1  pulse: start playback
stop_req  in  1  pulse: end recording or playback
loop_en  in  1  level: repeat playback after the last entry
play_out  out  1  replayed switch level
busy_rec  out  1  high in RECORD
busy_play  out  1  high in PLAY
entry_cnt  out  5  number of valid entries, 0..DEPTH
play_idx  out  5  entry currently replayed
done  out  1  one-cycle pulse when a non-looped playback ends
overflow  out  1  sticky: buffer filled during record; cleared by the next rec_req accepted

Behaviour:
- Reset values: state IDLE, play_out 0, busy_rec 0, busy_play 0, entry_cnt 0, play_idx 0, done 0, overflow 0, prescaler 0. Buffer contents are not cleared and are unreachable while entry_cnt is 0.
- FSM states: IDLE, RECORD, PLAY. Request priority in the same cycle: stop_req > rec_req > play_req. Requests not valid in the current state are ignored.
- Tick: the prescaler runs only in RECORD and PLAY and is zeroed on every state entry. tick is high on the cycle where the count equals TICK_DIV-1, then the count wraps to 0. The first tick after entry therefore comes TICK_DIV cycles after entry.
- IDLE + rec_req -> RECORD next cycle:
  - wr_idx=0, entry0.level=fake_switch, entry0.dur=0
  - entry_cnt=0, overflow=0
- IDLE + play_req: if entry_cnt==0, ignored. Otherwise -> PLAY with play_idx=0 and remain=max(entry0.dur,1); play_out=entry0.level on the cycle after the request.
- RECORD, per cycle:
  - If fake_switch != level[wr_idx] (edge):
    - wr_idx<DEPTH-1: wr_idx+1, new entry level=fake_switch, dur=0.
    - wr_idx==DEPTH-1: overflow=1, entry_cnt=DEPTH, -> IDLE; the new edge is not stored.
  - Otherwise, on tick: dur[wr_idx]+1, saturating at DUR_MAX.
  - Edge and tick in the same cycle: the edge wins, the closed entry is not incremented, and the new entry starts at 0.
  - stop_req: entry_cnt=wr_idx+1 -> IDLE. A stop in the same cycle as an edge takes priority and the edge is not stored.
- PLAY:
  - play_out=level[play_idx]. On tick, if remain>1 then remain-1.
  - Otherwise advance: if play_idx<entry_cnt-1, play_idx+1 and reload remain.
  - At the last entry with loop_en=1: play_idx=0 and reload.
  - At the last entry with loop_en=0: done=1 for one cycle, -> IDLE, play_out=0.
  - A zero-duration entry is held for 1 tick.
  - stop_req -> IDLE next cycle; play_out=0 and no done pulse.
- busy_rec and busy_play are decoded from the registered state.
- RST_n low mid-operation: all registers return to reset values immediately, without waiting for a clock edge. Recorded data is lost because entry_cnt becomes 0.
- Arithmetic: durations are unsigned DUR_W bits and never wrap. Index compares use the 5-bit width. entry_cnt never exceeds DEPTH.

Test Plan:
1. TICK_DIV=4. rec_req, switch 0 for 12 cycles, 1 for 8 cycles, then stop_req -> entry_cnt=2, durations {3,2}, levels {0,1}.
2. Replay of scenario 1 with loop_en=0 -> play_out 0 for 12 cycles, then 1 for 8 cycles; done pulses once; play_out=0 afterwards; busy_play falls with done.
3. Switch held for 200 ticks in RECORD -> dur saturates at 127, no wrap. Edge and tick in the same cycle -> the new entry reads dur 0 and the old entry is not incremented.
4. 20 edges during record -> overflow=1, entry_cnt=20, return to IDLE. The next rec_req clears overflow. play_req with entry_cnt=0 after reset -> stays IDLE.
5. loop_en=1 playback of 2 entries -> play_idx sequence 0,1,0,1 with no done pulse. stop_req -> IDLE next cycle, play_out=0.
6. RST_n asserted mid-PLAY, off the clock edge -> all outputs at reset values immediately. Simultaneous stop_req+rec_req in IDLE -> stays IDLE.
